// File: rtl/writeback_arbiter_if.sv
// Handshake and writeback bundle between the EX/MEM result paths, writeback_arbiter and register_file.
interface writeback_arbiter_if #(
  parameter int DWIDTH = 32
);
  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [4:0]        alu_rd_i;
  logic [DWIDTH-1:0] alu_data_i;
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic [4:0]        ld_rd_i;
  logic [DWIDTH-1:0] ld_data_i;
  logic              ld_pending_o;
  logic [4:0]        rd_o;
  logic [DWIDTH-1:0] datawb_o;
  logic              regwren_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output ld_valid_i, ld_rd_i, ld_data_i,
    input  alu_ready_o, ld_ready_o, ld_pending_o,
    input  rd_o, datawb_o, regwren_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  ld_valid_i, ld_rd_i, ld_data_i,
    output alu_ready_o, ld_ready_o, ld_pending_o,
    output rd_o, datawb_o, regwren_o
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU results and queued load responses onto one registered register-file write port.
// Optional feature macro: WB_LD_BYPASS_EN (lets a load skip the empty queue when the ALU is idle).
module writeback_arbiter #(
  parameter int DWIDTH   = 32,
  parameter int LQ_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  writeback_arbiter_if.slave bus
);
  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);

  logic [4:0]        q_rd   [LQ_DEPTH];
  logic [DWIDTH-1:0] q_data [LQ_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  logic              full, ready;
  logic              alu_issue, head_issue, bypass_issue;
  logic              push, pop;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic [DWIDTH-1:0] issue_data;

  logic [4:0]        rd_q;
  logic [DWIDTH-1:0] data_q;
  logic              wren_q;

  // Readiness comes from the registered count only, so a pop this cycle never frees a slot early.
  assign full  = (count == CW'(LQ_DEPTH));
  assign ready = !full;

  assign alu_issue  = bus.alu_valid_i && ready;
  assign head_issue = !alu_issue && (count != '0);

`ifdef WB_LD_BYPASS_EN
  assign bypass_issue = !alu_issue && (count == '0) && bus.ld_valid_i;
`else
  assign bypass_issue = 1'b0;
`endif

  assign push = bus.ld_valid_i && ready && !bypass_issue;
  assign pop  = head_issue;

  always_comb begin
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_data  = '0;
    if (alu_issue) begin
      issue_valid = 1'b1;
      issue_rd    = bus.alu_rd_i;
      issue_data  = bus.alu_data_i;
    end else if (head_issue) begin
      issue_valid = 1'b1;
      issue_rd    = q_rd[rd_ptr];
      issue_data  = q_data[rd_ptr];
    end else if (bypass_issue) begin
      issue_valid = 1'b1;
      issue_rd    = bus.ld_rd_i;
      issue_data  = bus.ld_data_i;
    end
  end

  // Queue storage needs no reset: entries are only read below the valid count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= bus.ld_rd_i;
      q_data[wr_ptr] <= bus.ld_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rd_q   <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(LQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(LQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      // Writes to x0 still consume the issue slot but never raise the enable.
      if (issue_valid) begin
        rd_q   <= issue_rd;
        data_q <= issue_data;
        wren_q <= (issue_rd != 5'd0);
      end else begin
        wren_q <= 1'b0;
      end
    end
  end

  assign bus.alu_ready_o  = ready;
  assign bus.ld_ready_o   = ready;
  assign bus.ld_pending_o = (count != '0);
  assign bus.rd_o         = rd_q;
  assign bus.datawb_o     = data_q;
  assign bus.regwren_o    = wren_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter; bypass expectations follow WB_LD_BYPASS_EN.
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  writeback_arbiter_if #(.DWIDTH(32)) bus ();

  writeback_arbiter #(.DWIDTH(32), .LQ_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid_i = 1'b0;
    bus.alu_rd_i    = '0;
    bus.alu_data_i  = '0;
    bus.ld_valid_i  = 1'b0;
    bus.ld_rd_i     = '0;
    bus.ld_data_i   = '0;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_wb(input string name, input logic wren, input logic [4:0] rd,
                        input logic [31:0] data);
    checks++;
    if (bus.regwren_o !== wren || bus.rd_o !== rd || bus.datawb_o !== data) begin
      failures++;
      $display("[TB] FAIL %s actual=wren %b rd %0d data %h required=wren %b rd %0d data %h",
               name, bus.regwren_o, bus.rd_o, bus.datawb_o, wren, rd, data);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_wb("reset_outputs", 1'b0, 5'd0, 32'h0);
    chk1("reset_pending", bus.ld_pending_o, 1'b0);
    chk1("reset_alu_ready", bus.alu_ready_o, 1'b1);
    chk1("reset_ld_ready", bus.ld_ready_o, 1'b1);
  endtask

  task automatic test_mid_reset();
    // ALU hogs the port so three loads pile up in the queue.
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid_i = 1'b1;
      bus.alu_rd_i    = 5'd2;
      bus.alu_data_i  = 32'h100 + i;
      bus.ld_valid_i  = 1'b1;
      bus.ld_rd_i     = 5'(10 + i);
      bus.ld_data_i   = 32'h200 + i;
      step();
    end
    idle_inputs();
    chk1("midrst_pending_before", bus.ld_pending_o, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("midrst_regwren", bus.regwren_o, 1'b0);
    chk1("midrst_pending", bus.ld_pending_o, 1'b0);
    chk1("midrst_alu_ready", bus.alu_ready_o, 1'b1);
    chk1("midrst_ld_ready", bus.ld_ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("midrst_no_write", bus.regwren_o, 1'b0);
    end
  endtask

  task automatic test_alu_single();
    idle_inputs();
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd5;
    bus.alu_data_i  = 32'hDEADBEEF;
    step();
    idle_inputs();
    chk_wb("alu_n1", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk_wb("alu_n2_hold", 1'b0, 5'd5, 32'hDEADBEEF);
  endtask

  task automatic test_alu_vs_load();
    idle_inputs();
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd3;
    bus.alu_data_i  = 32'h11;
    bus.ld_valid_i  = 1'b1;
    bus.ld_rd_i     = 5'd7;
    bus.ld_data_i   = 32'h22;
    step();
    idle_inputs();
    chk_wb("prio_n1_alu", 1'b1, 5'd3, 32'h11);
    chk1("prio_n1_pending", bus.ld_pending_o, 1'b1);
    step();
    chk_wb("prio_n2_load", 1'b1, 5'd7, 32'h22);
    chk1("prio_n2_pending", bus.ld_pending_o, 1'b0);
    step();
    chk1("prio_n3_idle", bus.regwren_o, 1'b0);
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      bus.alu_valid_i = 1'b1;
      bus.alu_rd_i    = 5'd20;
      bus.alu_data_i  = 32'hA0 + i;
      bus.ld_valid_i  = 1'b1;
      bus.ld_rd_i     = 5'(i);
      bus.ld_data_i   = 32'h300 + i;
      step();
      chk_wb("b2b_alu_fill", 1'b1, 5'd20, 32'hA0 + i);
    end
    bus.ld_valid_i = 1'b0;
    bus.alu_data_i = 32'hB0;
    chk1("b2b_full_ld_ready", bus.ld_ready_o, 1'b0);
    chk1("b2b_full_alu_ready", bus.alu_ready_o, 1'b0);
    step();
    chk_wb("b2b_head_rd1", 1'b1, 5'd1, 32'h301);
    chk1("b2b_alu_ready_again", bus.alu_ready_o, 1'b1);
    step();
    bus.alu_valid_i = 1'b0;
    chk_wb("b2b_alu_resumes", 1'b1, 5'd20, 32'hB0);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_wb("b2b_drain", 1'b1, 5'(i), 32'h300 + i);
    end
    step();
    chk1("b2b_done_wren", bus.regwren_o, 1'b0);
    chk1("b2b_done_pending", bus.ld_pending_o, 1'b0);
  endtask

  task automatic test_x0_load();
    idle_inputs();
    bus.ld_valid_i = 1'b1;
    bus.ld_rd_i    = 5'd0;
    bus.ld_data_i  = 32'hFFFFFFFF;
    step();
    idle_inputs();
    chk1("x0_n1_wren", bus.regwren_o, 1'b0);
`ifdef WB_LD_BYPASS_EN
    chk1("x0_n1_pending", bus.ld_pending_o, 1'b0);
`else
    chk1("x0_n1_pending", bus.ld_pending_o, 1'b1);
`endif
    step();
    chk1("x0_n2_wren", bus.regwren_o, 1'b0);
    chk1("x0_n2_pending", bus.ld_pending_o, 1'b0);
    chk1("x0_n2_rd", bus.rd_o == 5'd0, 1'b1);
  endtask

  task automatic test_load_latency();
    idle_inputs();
    bus.ld_valid_i = 1'b1;
    bus.ld_rd_i    = 5'd9;
    bus.ld_data_i  = 32'h5A;
    step();
    idle_inputs();
`ifdef WB_LD_BYPASS_EN
    chk_wb("lat_bypass_n1", 1'b1, 5'd9, 32'h5A);
    chk1("lat_bypass_pending", bus.ld_pending_o, 1'b0);
    step();
    chk1("lat_bypass_n2_wren", bus.regwren_o, 1'b0);
`else
    chk1("lat_n1_wren", bus.regwren_o, 1'b0);
    chk1("lat_n1_pending", bus.ld_pending_o, 1'b1);
    step();
    chk_wb("lat_n2", 1'b1, 5'd9, 32'h5A);
    chk1("lat_n2_pending", bus.ld_pending_o, 1'b0);
`endif
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mid_reset();
    test_alu_single();
    test_alu_vs_load();
    test_back_to_back();
    test_x0_load();
    test_load_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
